// File: rtl/hack_bus_pkg.sv
// hack_bus_pkg: shared defaults and frame FSM state encoding for the word-bus receiver
package hack_bus_pkg;
    localparam int WORD_W = 16;
    localparam int LANES = 8;
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/frame_lane_reg.sv
// frame_lane_reg: one lane word register with write enable and synchronous clear
module frame_lane_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // clear wins over write so a dropped frame never keeps a stale word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (clear) q <= '0;
        else if (we) q <= d;
    end
endmodule

// File: rtl/dmux8way16_frame.sv
// dmux8way16_frame: routes successive bus beats into lane registers and presents the assembled frame
module dmux8way16_frame
    import hack_bus_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int LANES = hack_bus_pkg::LANES,
    localparam int SEL_W = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    output logic [LANES*WIDTH-1:0] out_frame,
    output logic [LANES-1:0]       out_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SEL_W-1:0]       wr_sel,
    output logic [7:0]             frame_count
);
    state_t state, state_nx;
    logic accept, handshake, last, drop;
    logic [LANES-1:0] we;

    assign in_ready  = (state == FILL) & ~clear;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign handshake = out_valid & out_ready & ~clear;
    assign last      = (wr_sel == SEL_W'(LANES - 1)) | in_last;
    assign drop      = clear | handshake;
    assign we        = accept ? LANES'(1) << wr_sel : '0;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else state <= state_nx;
    end

    // next state: clear aborts, final word holds, handshake releases
    always_comb begin
        state_nx = state;
        if (clear) state_nx = FILL;
        else if (accept && last) state_nx = HOLD;
        else if (handshake) state_nx = FILL;
    end

    // write pointer, lane-written mask and delivered-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel      <= '0;
            out_mask    <= '0;
            frame_count <= '0;
        end else if (clear) begin
            wr_sel   <= '0;
            out_mask <= '0;
        end else if (handshake) begin
            out_mask    <= '0;
            frame_count <= frame_count + 8'd1;
        end else if (accept) begin
            out_mask[wr_sel] <= 1'b1;
            wr_sel           <= last ? '0 : wr_sel + SEL_W'(1);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        frame_lane_reg #(.WIDTH(WIDTH)) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .clear(drop),
            .we   (we[i]),
            .d    (in_data),
            .q    (out_frame[i*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_dmux8way16_frame.sv
// tb_dmux8way16_frame: directed vectors plus a queue-based frame model checked every cycle
`timescale 1ns/100ps
module tb_dmux8way16_frame;
    localparam int W = 16;
    localparam int L = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           clear = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_last = 1'b0;
    logic [L*W-1:0] out_frame;
    logic [L-1:0]   out_mask;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2:0]     wr_sel;
    logic [7:0]     frame_count;

    int n_vec = 0;
    int n_err = 0;

    dmux8way16_frame dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .out_frame(out_frame), .out_mask(out_mask),
        .out_valid(out_valid), .out_ready(out_ready), .wr_sel(wr_sel), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // model: the frame is just the list of words accepted so far
    logic [W-1:0] m_words[$];
    logic         m_hold = 1'b0;
    logic [7:0]   m_cnt = 8'd0;

    function automatic logic [127:0] m_frame();
        logic [127:0] f = '0;
        for (int i = 0; i < m_words.size(); i++) f[i*16 +: 16] = m_words[i];
        return f;
    endfunction

    function automatic logic [127:0] m_mask();
        return 128'((1 << m_words.size()) - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_words.delete();
            m_hold = 1'b0;
            m_cnt  = 8'd0;
        end else if (clear) begin
            m_words.delete();
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_words.delete();
                m_hold = 1'b0;
                m_cnt  = m_cnt + 8'd1;
            end
        end else if (in_valid) begin
            m_words.push_back(in_data);
            if (m_words.size() == L || in_last) m_hold = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("out_valid", 128'(out_valid), 128'(m_hold));
        chk("in_ready", 128'(in_ready), 128'(!m_hold && !clear));
        chk("out_frame", 128'(out_frame), m_frame());
        chk("out_mask", 128'(out_mask), m_mask());
        chk("wr_sel", 128'(wr_sel), m_hold ? 128'd0 : 128'(m_words.size()));
        chk("frame_count", 128'(frame_count), 128'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic last);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic deliver();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk("wait_valid", 128'(out_valid), 128'd1);
    endtask

    initial begin
        logic [W-1:0] sent[L];
        logic [127:0] packed_sent;
        #1 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_frame", 128'(out_frame), 128'd0);
        chk("rst_mask", 128'(out_mask), 128'd0);
        chk("rst_wr_sel", 128'(wr_sel), 128'd0);
        chk("rst_count", 128'(frame_count), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);

        // test 1: full frame
        for (int i = 0; i < L; i++) begin
            chk("t1_in_ready", 128'(in_ready), 128'd1);
            beat(16'(16'h1111 * (i + 1)), 1'b0);
        end
        chk("t1_valid", 128'(out_valid), 128'd1);
        chk("t1_frame", 128'(out_frame), 128'h8888_7777_6666_5555_4444_3333_2222_1111);
        chk("t1_mask", 128'(out_mask), 128'hFF);
        chk("t1_in_ready", 128'(in_ready), 128'd0);

        // test 2: handshake, then a new word into lane 0
        deliver();
        chk("t2_valid", 128'(out_valid), 128'd0);
        chk("t2_frame", 128'(out_frame), 128'd0);
        chk("t2_count", 128'(frame_count), 128'd1);
        chk("t2_wr_sel", 128'(wr_sel), 128'd0);
        beat(16'hC0DE, 1'b0);
        chk("t2_lane0", 128'(out_frame), 128'hC0DE);
        chk("t2_mask", 128'(out_mask), 128'h01);
        pulse_clear();

        // test 3: partial frame ended by in_last
        beat(16'hA001, 1'b0);
        beat(16'hA002, 1'b0);
        beat(16'hA003, 1'b1);
        chk("t3_valid", 128'(out_valid), 128'd1);
        chk("t3_frame", 128'(out_frame), 128'h0000_0000_0000_0000_0000_A003_A002_A001);
        chk("t3_mask", 128'(out_mask), 128'h07);
        deliver();
        chk("t3_count", 128'(frame_count), 128'd2);

        // test 4: clear mid-frame rejects the concurrent word
        for (int i = 0; i < 5; i++) beat(16'(16'h5001 + i), 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t4_mask", 128'(out_mask), 128'd0);
        chk("t4_wr_sel", 128'(wr_sel), 128'd0);
        chk("t4_valid", 128'(out_valid), 128'd0);
        chk("t4_frame", 128'(out_frame), 128'd0);
        beat(16'hBEEF, 1'b0);
        chk("t4_lane0", 128'(out_frame), 128'hBEEF);
        chk("t4_count", 128'(frame_count), 128'd2);

        // clear coinciding with a handshake: frame is not counted
        beat(16'h0001, 1'b1);
        chk("t4b_valid", 128'(out_valid), 128'd1);
        clear     = 1'b1;
        out_ready = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        chk("t4b_count", 128'(frame_count), 128'd2);
        chk("t4b_valid", 128'(out_valid), 128'd0);

        // test 5: 256 frames with random gaps, frame_count wraps
        for (int f = 0; f < 256; f++) begin
            packed_sent = '0;
            for (int w = 0; w < L; w++) begin
                repeat ($urandom_range(0, 2)) tick();
                sent[w] = 16'($urandom);
                packed_sent[w*16 +: 16] = sent[w];
                beat(sent[w], (w == L - 1) && f[0]);
            end
            wait_valid();
            chk("t5_frame", 128'(out_frame), packed_sent);
            repeat ($urandom_range(0, 2)) tick();
            deliver();
            if (f == 253) chk("t5_wrap", 128'(frame_count), 128'd0);
        end
        chk("t5_count", 128'(frame_count), 128'd2);

        // test 6: async reset mid-HOLD
        for (int i = 0; i < L; i++) beat(16'(16'h6000 + i), 1'b0);
        chk("t6_hold", 128'(out_valid), 128'd1);
        #2.3 rst_n = 1'b0;
        #1;
        chk("t6_valid", 128'(out_valid), 128'd0);
        chk("t6_frame", 128'(out_frame), 128'd0);
        chk("t6_mask", 128'(out_mask), 128'd0);
        chk("t6_count", 128'(frame_count), 128'd0);
        chk("t6_wr_sel", 128'(wr_sel), 128'd0);
        #2.1 rst_n = 1'b1;
        tick();
        chk("t6_in_ready", 128'(in_ready), 128'd1);
        chk("t6_valid_after", 128'(out_valid), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
